// File: rtl/win_seq.sv
// Frame sequencer ahead of the Hanning window multiplier: tags samples with a window index,
// inserts inter-frame gaps and tracks returned frames. Optional frame counter: WIN_SEQ_FRAME_CNT_EN.
module win_seq #(
  parameter int Dwidth = 16,
  parameter int Nwin   = 32,
  parameter int Iwidth = 5,
  parameter int Ngap   = 4,
  parameter int Fwidth = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [Fwidth-1:0] nframes,
  input  logic              s_valid,
  input  logic [Dwidth-1:0] s_real,
  input  logic [Dwidth-1:0] s_imag,
  output logic              s_ready,
  output logic              win_dv,
  output logic [Iwidth-1:0] win_index,
  output logic [Dwidth-1:0] win_real,
  output logic [Dwidth-1:0] win_imag,
  input  logic              ret_dv,
  input  logic [Iwidth-1:0] ret_index,
  output logic              busy,
  output logic              done,
  output logic [Fwidth-1:0] frame_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int GW = (Ngap > 1) ? $clog2(Ngap) : 1;
  localparam logic [GW-1:0]     GAP_LAST = GW'((Ngap > 0) ? Ngap - 1 : 0);
  localparam logic [Iwidth-1:0] IDX_LAST = Iwidth'(Nwin - 1);

  logic [1:0]        state;
  logic [Iwidth-1:0] idx;
  logic [Fwidth-1:0] issued, returned, nf;
  logic [GW-1:0]     gap_cnt;
  logic              stop_pend;
  logic              ret_hit;
  logic              hs;
  logic [Fwidth-1:0] issued_nx;

  assign s_ready   = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DRAIN) && (returned == issued);
  assign hs        = s_valid && s_ready;
  assign issued_nx = issued + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      issued    <= '0;
      returned  <= '0;
      nf        <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      ret_hit   <= 1'b0;
      win_dv    <= 1'b0;
      win_index <= '0;
      win_real  <= '0;
      win_imag  <= '0;
    end else begin
      win_dv <= 1'b0;
      if (hs) begin
        win_dv    <= 1'b1;
        win_index <= idx;
        win_real  <= s_real;
        win_imag  <= s_imag;
      end
      // Last-index returns are registered before counting, so done follows one cycle later.
      ret_hit <= (state != S_IDLE) && ret_dv && (ret_index == IDX_LAST);
      if ((state != S_IDLE) && ret_hit) returned <= returned + 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            idx       <= '0;
            issued    <= '0;
            returned  <= '0;
            stop_pend <= 1'b0;
            nf        <= nframes;
          end
        end
        S_RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (hs) begin
            if (idx == IDX_LAST) begin
              idx    <= '0;
              issued <= issued_nx;
              if (stop_pend || stop || ((nf != '0) && (issued_nx == nf))) begin
                state <= S_DRAIN;
              end else if (Ngap > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else if ((stop || stop_pend) && (idx == '0)) begin
            // Nothing of this frame accepted yet: finish without opening it.
            state <= S_DRAIN;
          end
        end
        S_GAP: begin
          if (stop || stop_pend) begin
            stop_pend <= 1'b1;
            state     <= S_DRAIN;
          end else if (gap_cnt == GAP_LAST) begin
            state <= S_RUN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          if (done) state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WIN_SEQ_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            frame_cnt <= '0;
    else if ((state != S_IDLE) && ret_hit) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
